ekf_predict_seq: RTL and testbench
==================================

# ekf_predict_seq

Sequential, parametrised EKF prediction stage for the PMSM observer. It computes the predicted state (ialphae, ibetae, omegae, thetae) and the 4x4 Jacobian F and its transpose from one measurement/state sample. The ten Q-format products run on a single shared multiplier under an FSM, instead of ten parallel multipliers. It sits between the sin/cos generator and the covariance-predict block, with valid/ready handshakes on both sides.

## Interface
- N, 32, word width (two's complement, Q fractional bits)
- Q, 18, fractional bits
- TS, 0.00001, sample period [s]
- RS, 1.477, stator resistance [ohm]
- LAMBDA, 0.2026, flux linkage [Wb]
- LS, 0.0211, stator inductance [H]
- Derived constants: TS_LS=(TS/LS)·2^Q, RS_TS_LS=(RS·TS/LS)·2^Q, LTL=(LAMBDA·TS/LS)·2^Q, T=TS·2^Q, SF=2^Q, F00=SF−RS_TS_LS, PI_Q=π·2^Q.
  - All are converted with Verilog real-to-integer rounding (nearest, ties away from zero).
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in IDLE
- ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta  in  N each  Q-format sample
- out_valid  out  1  results valid; held until accepted
- out_ready  in  1  downstream accepts
- ialphae, ibetae, omegae, thetae  out  N each  predicted state
- F, F_transpose  out  16N  Jacobian; entry Fr[c] at F[(4r+c)N +: N], and at F_transpose[(4c+r)N +: N]
- ovf  out  1  a product saturated during this transaction

## Operation
- States: IDLE, RUN (step counter 0..9), FIN, DONE.
- IDLE: in_ready=1. When in_valid is high, capture all eight inputs, clear ovf, clear step, and go to RUN.
- RUN: one product per cycle. A product is (a·b) as a 2N-bit value, arithmetic right shift by Q, then saturated to N bits; saturation sets ovf.
  - Step order:
    - 0: valpha·TS_LS
    - 1: ialpha·RS_TS_LS
    - 2: m2 = omega·LTL
    - 3: p3 = stheta·m2
    - 4: vbeta·TS_LS
    - 5: ibeta·RS_TS_LS
    - 6: p6 = ctheta·m2
    - 7: omega·T
    - 8: LTL·stheta
    - 9: LTL·ctheta
  - After step 9, go to FIN.
- FIN (1 cycle): register all results and go to DONE. Sums use wrapping N-bit adds.
  - ialphae = ialpha + p0 − p1 + p3
  - ibetae = ibeta + p4 − p5 − p6
  - omegae = omega
  - thetae = theta + p7, with optional wrap (see Configuration)
  - Row 0 of F: F00, 0, p8, p6
  - Row 1 of F: 0, F00, −p9, p3
  - Row 2 of F: 0, 0, SF, 0
  - Row 3 of F: 0, 0, T, SF
- DONE: out_valid=1. When out_ready is high, go to IDLE.
- Outputs hold their values from FIN until the next FIN, including through IDLE.
- Inputs are sampled only on the accept edge; input changes during RUN, FIN or DONE have no effect.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, ovf=0, all state/F outputs 0.
- Latency: for an accept on edge E0, out_valid rises after edge E11.
- Minimum initiation interval is 13 cycles (out_ready held high): one DONE cycle, then one IDLE cycle before the next accept.
- in_ready and out_valid are never high together.
- Reset asserted mid-transaction: async return to IDLE with all outputs zeroed and the transaction discarded. Operation resumes on the first edge after deassertion.
- ovf is sticky from accept through DONE and is valid together with out_valid.

## Configuration
- THETA_WRAP_EN defined: after the add, if thetae ≥ PI_Q subtract 2·PI_Q; else if thetae < −PI_Q add 2·PI_Q. Exactly one correction is applied.
- THETA_WRAP_EN undefined: thetae = theta + p7 with plain N-bit wrap.

## Test plan
- Input valpha=262144 (1.0), all other inputs 0 -> ialphae=(262144·TS_LS)>>18 (=124 at defaults), ibetae=omegae=thetae=0, F0[0]=F1[1]=F00, F2[2]=F3[3]=262144, ovf=0, out_valid exactly 11 cycles after accept.
- Input omega=100·2^18, ctheta=2^18, all else 0 -> ibetae=−100·LTL, thetae=100·T, F0[3]=100·LTL, F1[2]=−LTL, F1[3]=0; F_transpose entry (c=3,r=0) equals F0[3].
- Input theta=PI_Q−1, omega=2^18 -> with THETA_WRAP_EN: thetae=PI_Q−1+T−2·PI_Q; without it: thetae=PI_Q−1+T.
- Input ialpha=0x7FFFFFFF -> step-1 product saturates, ovf=1 at out_valid. The next transaction with small inputs reports ovf=0.
- Hold out_ready=0 for 5 cycles in DONE while toggling all inputs -> out_valid stays 1, outputs stay stable, in_ready=0. out_ready=1 gives IDLE on the next edge.
- Assert reset at RUN step 5 -> all outputs 0, out_valid=0, in_ready=1. A fresh transaction then completes correctly.

Source files
------------

// File: rtl/ekf_predict_seq.sv
// ekf_predict_seq: sequential EKF prediction stage for the PMSM observer.
// Captures one measurement/state sample. Computes the ten Q-format products
// on one shared multiplier, one product per cycle. Then registers the
// predicted state and the 4x4 Jacobian F together with its transpose.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   ialpha..ctheta      N-bit Q-format input sample
//   out_valid/out_ready output handshake; out_valid is held until accepted
//   ialphae..thetae     predicted state
//   F, F_transpose      Jacobian; Fr[c] is at F[(4r+c)N +: N]
//   ovf                 a product saturated during this transaction
//
// Optional feature: define THETA_WRAP_EN to fold thetae into [-pi, pi).
module ekf_predict_seq #(
    parameter int unsigned N      = 32,
    parameter int unsigned Q      = 18,
    parameter real         TS     = 0.00001,
    parameter real         RS     = 1.477,
    parameter real         LAMBDA = 0.2026,
    parameter real         LS     = 0.0211
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  ialpha,
    input  logic [N-1:0]  ibeta,
    input  logic [N-1:0]  valpha,
    input  logic [N-1:0]  vbeta,
    input  logic [N-1:0]  omega,
    input  logic [N-1:0]  theta,
    input  logic [N-1:0]  stheta,
    input  logic [N-1:0]  ctheta,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  ialphae,
    output logic [N-1:0]  ibetae,
    output logic [N-1:0]  omegae,
    output logic [N-1:0]  thetae,
    output logic [16*N-1:0] F,
    output logic [16*N-1:0] F_transpose,
    output logic          ovf
);

    localparam int unsigned STEP_W   = 4;
    localparam int unsigned NPROD    = 10;
    localparam int unsigned LAST_STEP = NPROD - 1;

    // Q-format constants, rounded to nearest (ties away from zero) by the cast
    localparam longint TS_LS_I    = longint'((TS / LS) * (2.0 ** Q));
    localparam longint RS_TS_LS_I = longint'((RS * TS / LS) * (2.0 ** Q));
    localparam longint LTL_I      = longint'((LAMBDA * TS / LS) * (2.0 ** Q));
    localparam longint T_I        = longint'(TS * (2.0 ** Q));
    localparam longint SF_I       = longint'(2.0 ** Q);
    localparam longint PI_I       = longint'(3.14159265358979323846 * (2.0 ** Q));

    localparam logic signed [N-1:0] TS_LS    = N'(TS_LS_I);
    localparam logic signed [N-1:0] RS_TS_LS = N'(RS_TS_LS_I);
    localparam logic signed [N-1:0] LTL      = N'(LTL_I);
    localparam logic signed [N-1:0] T        = N'(T_I);
    localparam logic signed [N-1:0] SF       = N'(SF_I);
    localparam logic signed [N-1:0] F00      = N'(SF_I - RS_TS_LS_I);
    localparam logic signed [N-1:0] PI_Q     = N'(PI_I);
    localparam logic signed [N-1:0] NEG_PI_Q = N'(-PI_I);
    localparam logic signed [N-1:0] TWO_PI_Q = N'(2 * PI_I);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;

    logic signed [N-1:0] r_ialpha, r_ibeta, r_valpha, r_vbeta;
    logic signed [N-1:0] r_omega, r_theta, r_stheta, r_ctheta;
    logic signed [N-1:0] prod [NPROD];

    logic signed [N-1:0]   mul_a, mul_b, mul_sat;
    logic signed [2*N-1:0] a_ext, b_ext, mul_full, mul_sh;
    logic                  mul_ovf;

    logic signed [N-1:0] ia_nxt, ib_nxt, th_sum, th_nxt;
    logic signed [N-1:0] fm [4][4];
    logic [16*N-1:0]     f_pack, ft_pack;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state logic and step sequencing
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                end
            end
            RUN: begin
                if (step == STEP_W'(LAST_STEP)) begin
                    state_nxt = FIN;
                end else begin
                    step_nxt = step + STEP_W'(1);
                end
            end
            FIN:  state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand select for the shared multiplier; m2 = prod[2] feeds steps 3 and 6
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step)
            4'd0: begin mul_a = r_valpha; mul_b = TS_LS;    end
            4'd1: begin mul_a = r_ialpha; mul_b = RS_TS_LS; end
            4'd2: begin mul_a = r_omega;  mul_b = LTL;      end
            4'd3: begin mul_a = r_stheta; mul_b = prod[2];  end
            4'd4: begin mul_a = r_vbeta;  mul_b = TS_LS;    end
            4'd5: begin mul_a = r_ibeta;  mul_b = RS_TS_LS; end
            4'd6: begin mul_a = r_ctheta; mul_b = prod[2];  end
            4'd7: begin mul_a = r_omega;  mul_b = T;        end
            4'd8: begin mul_a = LTL;      mul_b = r_stheta; end
            4'd9: begin mul_a = LTL;      mul_b = r_ctheta; end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    // Full-width product, arithmetic shift by Q, saturate to N bits
    always_comb begin
        a_ext    = {{N{mul_a[N-1]}}, mul_a};
        b_ext    = {{N{mul_b[N-1]}}, mul_b};
        mul_full = a_ext * b_ext;
        mul_sh   = mul_full >>> Q;
        // Fits in N bits only when the top N+1 bits are all equal
        mul_ovf  = ~(&mul_sh[2*N-1:N-1]) & (|mul_sh[2*N-1:N-1]);
        if (mul_ovf) begin
            mul_sat = mul_sh[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            mul_sat = mul_sh[N-1:0];
        end
    end

    // Result sums (wrapping) and Jacobian assembly
    always_comb begin
        ia_nxt = r_ialpha + prod[0] - prod[1] + prod[3];
        ib_nxt = r_ibeta + prod[4] - prod[5] - prod[6];
        th_sum = r_theta + prod[7];
`ifdef THETA_WRAP_EN
        if (th_sum >= PI_Q) begin
            th_nxt = th_sum - TWO_PI_Q;
        end else if (th_sum < NEG_PI_Q) begin
            th_nxt = th_sum + TWO_PI_Q;
        end else begin
            th_nxt = th_sum;
        end
`else
        th_nxt = th_sum;
`endif
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                fm[r][c] = '0;
            end
        end
        fm[0][0] = F00;
        fm[0][2] = prod[8];
        fm[0][3] = prod[6];
        fm[1][1] = F00;
        fm[1][2] = -prod[9];
        fm[1][3] = prod[3];
        fm[2][2] = SF;
        fm[3][2] = T;
        fm[3][3] = SF;
        f_pack  = '0;
        ft_pack = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                f_pack[(4*r+c)*N +: N]  = fm[r][c];
                ft_pack[(4*c+r)*N +: N] = fm[r][c];
            end
        end
    end

    // Handshake flags follow the next state so they are registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Input capture, product accumulation, sticky overflow and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ialpha    <= '0;
            r_ibeta     <= '0;
            r_valpha    <= '0;
            r_vbeta     <= '0;
            r_omega     <= '0;
            r_theta     <= '0;
            r_stheta    <= '0;
            r_ctheta    <= '0;
            for (int i = 0; i < NPROD; i++) begin
                prod[i] <= '0;
            end
            ovf         <= 1'b0;
            ialphae     <= '0;
            ibetae      <= '0;
            omegae      <= '0;
            thetae      <= '0;
            F           <= '0;
            F_transpose <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_ialpha <= ialpha;
                        r_ibeta  <= ibeta;
                        r_valpha <= valpha;
                        r_vbeta  <= vbeta;
                        r_omega  <= omega;
                        r_theta  <= theta;
                        r_stheta <= stheta;
                        r_ctheta <= ctheta;
                        ovf      <= 1'b0;
                    end
                end
                RUN: begin
                    prod[step] <= mul_sat;
                    if (mul_ovf) begin
                        ovf <= 1'b1;
                    end
                end
                FIN: begin
                    ialphae     <= ia_nxt;
                    ibetae      <= ib_nxt;
                    omegae      <= r_omega;
                    thetae      <= th_nxt;
                    F           <= f_pack;
                    F_transpose <= ft_pack;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ekf_predict_seq.sv
// Self-checking bench for ekf_predict_seq. Instance 0 uses the default
// constants. Instance 1 uses TS = 1.0, so its products are large enough
// to reach saturation. Expected results are queued when a sample is
// driven and are compared when out_valid is seen.
module tb_ekf_predict_seq;

    typedef struct {
        int ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta;
    } in_t;

    typedef struct {
        logic [31:0]  ia, ib, om, th;
        logic [511:0] f, ft;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, out_ready;
    logic [31:0] ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta;

    logic         ir_o [2];
    logic         ov_o [2];
    logic         ovf_o [2];
    logic [31:0]  ia_o [2];
    logic [31:0]  ib_o [2];
    logic [31:0]  om_o [2];
    logic [31:0]  th_o [2];
    logic [511:0] f_o [2];
    logic [511:0] ft_o [2];

    int n_checks = 0;
    int n_err = 0;
    exp_t sbq[$];

    longint k_ts_ls [2];
    longint k_rs [2];
    longint k_ltl [2];
    longint k_t [2];
    longint k_f00 [2];
    longint k_pi;

    always #5 clk = ~clk;

    ekf_predict_seq dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[0]),
        .ialpha(ialpha), .ibeta(ibeta), .valpha(valpha), .vbeta(vbeta),
        .omega(omega), .theta(theta), .stheta(stheta), .ctheta(ctheta),
        .out_valid(ov_o[0]), .out_ready(out_ready),
        .ialphae(ia_o[0]), .ibetae(ib_o[0]), .omegae(om_o[0]), .thetae(th_o[0]),
        .F(f_o[0]), .F_transpose(ft_o[0]), .ovf(ovf_o[0])
    );

    ekf_predict_seq #(.TS(1.0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[1]),
        .ialpha(ialpha), .ibeta(ibeta), .valpha(valpha), .vbeta(vbeta),
        .omega(omega), .theta(theta), .stheta(stheta), .ctheta(ctheta),
        .out_valid(ov_o[1]), .out_ready(out_ready),
        .ialphae(ia_o[1]), .ibetae(ib_o[1]), .omegae(om_o[1]), .thetae(th_o[1]),
        .F(f_o[1]), .F_transpose(ft_o[1]), .ovf(ovf_o[1])
    );

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Q-format product with saturation, as a reference
    function automatic int mulq(input int a, input longint b, inout logic ov);
        longint p;
        p = (longint'(a) * b) >>> 18;
        if (p > 64'sd2147483647) begin
            ov = 1'b1;
            return 32'sh7FFFFFFF;
        end
        if (p < -64'sd2147483648) begin
            ov = 1'b1;
            return 32'sh80000000;
        end
        return int'(p);
    endfunction

    function automatic exp_t model(input in_t x, input int k);
        exp_t e;
        logic ov;
        int p [10];
        int fm [4][4];
        int th;
        ov = 1'b0;
        p[0] = mulq(x.valpha, k_ts_ls[k], ov);
        p[1] = mulq(x.ialpha, k_rs[k], ov);
        p[2] = mulq(x.omega, k_ltl[k], ov);
        p[3] = mulq(x.stheta, longint'(p[2]), ov);
        p[4] = mulq(x.vbeta, k_ts_ls[k], ov);
        p[5] = mulq(x.ibeta, k_rs[k], ov);
        p[6] = mulq(x.ctheta, longint'(p[2]), ov);
        p[7] = mulq(x.omega, k_t[k], ov);
        p[8] = mulq(int'(k_ltl[k]), longint'(x.stheta), ov);
        p[9] = mulq(int'(k_ltl[k]), longint'(x.ctheta), ov);
        e.ia = x.ialpha + p[0] - p[1] + p[3];
        e.ib = x.ibeta + p[4] - p[5] - p[6];
        e.om = x.omega;
        th = x.theta + p[7];
`ifdef THETA_WRAP_EN
        if (longint'(th) >= k_pi) th = th - int'(2 * k_pi);
        else if (longint'(th) < -k_pi) th = th + int'(2 * k_pi);
`endif
        e.th = th;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                fm[r][c] = 0;
        fm[0][0] = int'(k_f00[k]); fm[0][2] = p[8]; fm[0][3] = p[6];
        fm[1][1] = int'(k_f00[k]); fm[1][2] = -p[9]; fm[1][3] = p[3];
        fm[2][2] = 262144;
        fm[3][2] = int'(k_t[k]); fm[3][3] = 262144;
        e.f = '0;
        e.ft = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                e.f[(4*r+c)*32 +: 32]  = fm[r][c];
                e.ft[(4*c+r)*32 +: 32] = fm[r][c];
            end
        e.ovf = ov;
        return e;
    endfunction

    task automatic drive(input in_t x);
        ialpha = x.ialpha; ibeta = x.ibeta; valpha = x.valpha; vbeta = x.vbeta;
        omega = x.omega; theta = x.theta; stheta = x.stheta; ctheta = x.ctheta;
    endtask

    function automatic in_t rnd_in();
        in_t x;
        x.ialpha = int'($urandom); x.ibeta = int'($urandom);
        x.valpha = int'($urandom); x.vbeta = int'($urandom);
        x.omega = int'($urandom); x.theta = int'($urandom);
        x.stheta = int'($urandom); x.ctheta = int'($urandom);
        return x;
    endfunction

    function automatic in_t zero_in();
        in_t x;
        x = '{default: 0};
        return x;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 512'(ir_o[0]), 512'(1));
        check({tag, "_out_valid"}, 512'(ov_o[0]), 512'(0));
    endtask

    // One transaction; hold keeps out_ready low in DONE, rst_mid resets at step 5
    task automatic txn(input in_t x, input bit hold, input bit rst_mid);
        int n;
        exp_t e [2];
        n = 0;
        while (!ir_o[0] && n < 40) begin @(negedge clk); n++; end
        check("accept_wait", 512'(ir_o[0]), 512'(1));
        drive(x);
        in_valid = 1'b1;
        sbq.push_back(model(x, 0));
        sbq.push_back(model(x, 1));
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_ready", 512'(ir_o[0]), 512'(0));
        if (rst_mid) begin
            repeat (5) @(negedge clk);
            reset = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                check("rst_ia", 512'(ia_o[k]), 512'(0));
                check("rst_th", 512'(th_o[k]), 512'(0));
                check("rst_f", f_o[k], 512'(0));
                check("rst_ft", ft_o[k], 512'(0));
                check("rst_ovf", 512'(ovf_o[k]), 512'(0));
                check("rst_ov", 512'(ov_o[k]), 512'(0));
                check("rst_ir", 512'(ir_o[k]), 512'(1));
            end
            void'(sbq.pop_back());
            void'(sbq.pop_back());
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        out_ready = !hold;
        n = 0;
        while (!ov_o[0] && n < 40) begin @(negedge clk); n++; end
        check("latency", 512'(n), 512'(11));
        for (int k = 0; k < 2; k++) begin
            e[k] = sbq.pop_front();
            check("ialphae", 512'(ia_o[k]), 512'(e[k].ia));
            check("ibetae", 512'(ib_o[k]), 512'(e[k].ib));
            check("omegae", 512'(om_o[k]), 512'(e[k].om));
            check("thetae", 512'(th_o[k]), 512'(e[k].th));
            check("F", f_o[k], e[k].f);
            check("F_transpose", ft_o[k], e[k].ft);
            check("ovf", 512'(ovf_o[k]), 512'(e[k].ovf));
            check("out_valid", 512'(ov_o[k]), 512'(1));
            check("no_in_ready", 512'(ir_o[k]), 512'(0));
        end
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                drive(rnd_in());
                in_valid = 1'(i & 1);
                @(negedge clk);
                check("hold_out_valid", 512'(ov_o[0]), 512'(1));
                check("hold_in_ready", 512'(ir_o[0]), 512'(0));
                check("hold_ialphae", 512'(ia_o[0]), 512'(e[0].ia));
                check("hold_thetae", 512'(th_o[0]), 512'(e[0].th));
                check("hold_F", f_o[0], e[0].f);
            end
            in_valid = 1'b0;
            drive(zero_in());
            out_ready = 1'b1;
        end
        @(negedge clk);
        check_idle("after_done");
        check("kept_ialphae", 512'(ia_o[0]), 512'(e[0].ia));
    endtask

    initial begin
        in_t x;
        real ts [2];
        ts[0] = 0.00001;
        ts[1] = 1.0;
        for (int k = 0; k < 2; k++) begin
            k_ts_ls[k] = longint'((ts[k] / 0.0211) * 262144.0);
            k_rs[k]    = longint'((1.477 * ts[k] / 0.0211) * 262144.0);
            k_ltl[k]   = longint'((0.2026 * ts[k] / 0.0211) * 262144.0);
            k_t[k]     = longint'(ts[k] * 262144.0);
            k_f00[k]   = 262144 - k_rs[k];
        end
        k_pi = longint'(3.14159265358979323846 * 262144.0);

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(zero_in());
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_in_ready", 512'(ir_o[k]), 512'(1));
            check("reset_out_valid", 512'(ov_o[k]), 512'(0));
            check("reset_ovf", 512'(ovf_o[k]), 512'(0));
            check("reset_ialphae", 512'(ia_o[k]), 512'(0));
            check("reset_thetae", 512'(th_o[k]), 512'(0));
            check("reset_F", f_o[k], 512'(0));
        end
        reset = 1'b1;
        @(negedge clk);

        // Unit valpha: ialphae = (2^18 * TS_LS) >> 18
        x = zero_in(); x.valpha = 262144;
        txn(x, 1'b0, 1'b0);
        // Speed with cos = 1: exercises p6, p7, p9
        x = zero_in(); x.omega = 100 * 262144; x.ctheta = 262144;
        txn(x, 1'b0, 1'b0);
        // Angle just below pi plus one step
        x = zero_in(); x.theta = int'(k_pi) - 1; x.omega = 262144;
        txn(x, 1'b0, 1'b0);
        // Largest ialpha: saturates in the TS = 1.0 instance
        x = zero_in(); x.ialpha = 32'sh7FFFFFFF;
        txn(x, 1'b0, 1'b0);
        // Small mixed sample: ovf must be cleared again
        x = zero_in(); x.valpha = 1000; x.ibeta = -5000; x.stheta = 100000;
        x.ctheta = -200000; x.omega = 3000000; x.theta = -900000;
        txn(x, 1'b0, 1'b0);
        // Most negative angle sum
        x = zero_in(); x.theta = -int'(k_pi) - 2; x.omega = -262144;
        txn(x, 1'b0, 1'b0);
        // Back-pressure in DONE with inputs toggling
        x = zero_in(); x.vbeta = 500000; x.ialpha = 70000; x.stheta = 262144; x.omega = 262144 * 50;
        txn(x, 1'b1, 1'b0);
        // Reset at RUN step 5, then a fresh transaction
        x = zero_in(); x.valpha = 262144; x.omega = 262144;
        txn(x, 1'b0, 1'b1);
        txn(x, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            txn(rnd_in(), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
